// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, read-controller state type and keep-mask helper
// for the byte-FIFO pack reader.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int MAX_PACK   = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        FLUSH
    } rd_state_t;

    // Low 'cnt' bits set: lanes 0..cnt-1 carry valid bytes.
    function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned cnt);
        return MAX_PACK'((32'd1 << cnt) - 32'd1);
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// pack_out_reg: single-slot output register for the packed-word valid/ready stream;
// holds data/keep stable until accepted.
module pack_out_reg #(
    parameter int W = 16,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] ld_data,
    input  logic [K-1:0] ld_keep,
    input  logic         m_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic [K-1:0] m_keep,
    output logic         slot_free
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic [K-1:0] keep_q;

    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_keep    = keep_q;
    assign slot_free = !valid_q || m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= ld_data;
            keep_q  <= ld_keep;
        end else if (m_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains the byte FIFO and packs PACK bytes little-endian into
// one word on a valid/ready stream; flush emits a trailing partial word with keep.
module fifo_pack_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_W-1:0]      fifo_data,
    output logic                   fifo_re,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W*PACK-1:0] m_data,
    output logic [PACK-1:0]        m_keep
);

    localparam int CW = $clog2(PACK + 1);
    localparam int WW = DATA_W * PACK;

    rd_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_cap;
    logic                  infl_q;
    logic [WW-1:0]         asm_q, asm_d, asm_cap;
    logic [MAX_PACK-1:0]   km;
    logic [PACK-1:0]       keep;
    logic                  slot_free, load, load_full, flush_pend, flush_clr;

    assign flush_pend = state_q == FLUSH;

    always_comb begin
        asm_cap = asm_q;
        if (infl_q)
            asm_cap[32'(cnt_q) * DATA_W +: DATA_W] = fifo_data;
        cnt_cap   = cnt_q + CW'(infl_q);
        load_full = cnt_cap == CW'(PACK) && slot_free;
        // A pending flush waits for the in-flight byte so it lands in this word.
        flush_clr = flush_pend && !infl_q && slot_free;
        load      = load_full || (flush_clr && cnt_q != '0);
        km        = keep_mask(32'(cnt_q));
        keep      = load_full ? '1 : km[PACK-1:0];
        cnt_d     = load ? '0 : cnt_cap;
        asm_d     = load ? '0 : asm_cap;
        state_d   = (flush_pend ? !flush_clr : flush) ? FLUSH
                  : cnt_d == '0 ? IDLE
                  : cnt_d == CW'(PACK) ? FULL : COLLECT;
    end

    // Completing-and-loading frees the assembly register in the same cycle,
    // so reading continues back-to-back at one byte per cycle.
    assign fifo_re = !reset && !fifo_empty && !flush_pend
                   && (load_full || cnt_cap < CW'(PACK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            infl_q  <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            infl_q  <= fifo_re;
            asm_q   <= asm_d;
        end
    end

    pack_out_reg #(
        .W (WW),
        .K (PACK)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .ld_data   (asm_cap),
        .ld_keep   (keep),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .slot_free (slot_free)
    );

endmodule
